dsp_addsub_arbiter: RTL and testbench

- Shares one DSP-based 32-bit add/subtract unit between two requesters: port 0 (ALU) and port 1 (address/branch-compare unit).
- Per cycle: round-robin arbitration, drives the shared DSP operands and the add/sub select, registers the DSP result, and returns it to the granted requester through a valid/ready response slot.
- Sits between execute-stage requesters and the DSP add/sub instance.
- Also keeps saturating per-port grant counters and a contention counter for performance debug.

---
 rtl/dsp_addsub_arbiter_pkg.sv | 16 +
 rtl/rr_arb2.sv | 30 +++
 rtl/dsp_addsub_arbiter.sv | 121 ++++++++++++
 tb/tb_dsp_addsub_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dsp_addsub_arbiter_pkg.sv
// Shared constants and types for the two-port DSP add/sub arbiter.
// Op encodings match the dsp_sub control bit; port indices name the two requesters.
package dsp_addsub_arbiter_pkg;

    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;
    localparam int   PORT_ALU  = 0;
    localparam int   PORT_ADDR = 1;
    localparam int   NUM_PORTS = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The registered pointer remembers the last winner,
// so the other port wins the next tie; after reset port 0 is preferred.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    // Set when port 1 won last, meaning port 0 wins the next tie.
    logic last_p1;

    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_p1 ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_p1 <= 1'b1;
        else if (|grant)
            last_p1 <= grant[1];
    end

endmodule

// File: rtl/dsp_addsub_arbiter.sv
// Shares one combinational DSP add/sub unit between the ALU and address ports.
// One-cycle latency into per-port response slots, plus saturating perf counters.
module dsp_addsub_arbiter
    import dsp_addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_sub,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data0,
    output logic [WIDTH-1:0] rsp_data1,
    output logic [WIDTH-1:0] dsp_in1,
    output logic [WIDTH-1:0] dsp_in2,
    output logic             dsp_sub,
    input  logic [WIDTH-1:0] dsp_out,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_PORTS-1:0]            eligible;
    logic [NUM_PORTS-1:0]            grant;
    logic [NUM_PORTS-1:0][WIDTH-1:0] req_a, req_b;
    logic [NUM_PORTS-1:0][WIDTH-1:0] rsp_data_q;
    logic [NUM_PORTS-1:0][CNT_W-1:0] grant_cnt_q;
    logic [WIDTH-1:0]                in1_q, in2_q;
    logic                            sub_q;

    assign req_a = {req_a1, req_a0};
    assign req_b = {req_b1, req_b0};

    // A full slot that is draining this cycle can take a new request.
    assign eligible  = req_valid & (~rsp_valid | rsp_ready);
    assign req_ready = grant;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .grant    (grant)
    );

    // Operands follow the winner; idle cycles replay the last values so the DSP stays quiet.
    always_comb begin
        dsp_in1 = in1_q;
        dsp_in2 = in2_q;
        dsp_sub = sub_q;
        if (|grant) begin
            dsp_in1 = req_a[grant[PORT_ADDR]];
            dsp_in2 = req_b[grant[PORT_ADDR]];
            dsp_sub = req_sub[grant[PORT_ADDR]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in1_q <= '0;
            in2_q <= '0;
            sub_q <= OP_ADD;
        end else if (|grant) begin
            in1_q <= dsp_in1;
            in2_q <= dsp_in2;
            sub_q <= dsp_sub;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
        slot_state_e state_q, state_d;

        always_comb begin
            state_d = state_q;
            if (grant[i])
                state_d = SLOT_FULL;
            else if (state_q == SLOT_FULL && rsp_ready[i])
                state_d = SLOT_EMPTY;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q        <= SLOT_EMPTY;
                rsp_data_q[i]  <= '0;
                grant_cnt_q[i] <= '0;
            end else begin
                state_q <= state_d;
                if (grant[i]) begin
                    rsp_data_q[i] <= dsp_out;
                    if (grant_cnt_q[i] != CNT_MAX)
                        grant_cnt_q[i] <= grant_cnt_q[i] + CNT_ONE;
                end
            end
        end

        assign rsp_valid[i] = (state_q == SLOT_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if (&eligible && conflict_cnt != CNT_MAX)
            conflict_cnt <= conflict_cnt + CNT_ONE;
    end

    assign rsp_data0  = rsp_data_q[PORT_ALU];
    assign rsp_data1  = rsp_data_q[PORT_ADDR];
    assign grant_cnt0 = grant_cnt_q[PORT_ALU];
    assign grant_cnt1 = grant_cnt_q[PORT_ADDR];

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Directed bench for dsp_addsub_arbiter: a behavioural DSP loops back each instance,
// and a second instance with 4-bit counters covers saturation.
module tb_dsp_addsub_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid, req_sub, rsp_ready;
    logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;

    logic [1:0]       req_ready, rsp_valid;
    logic [WIDTH-1:0] rsp_data0, rsp_data1, dsp_in1, dsp_in2, dsp_out;
    logic             dsp_sub;
    logic [15:0]      grant_cnt0, grant_cnt1, conflict_cnt;

    logic [1:0]       s_req_ready, s_rsp_valid;
    logic [WIDTH-1:0] s_rsp_data0, s_rsp_data1, s_dsp_in1, s_dsp_in2, s_dsp_out;
    logic             s_dsp_sub;
    logic [3:0]       s_grant_cnt0, s_grant_cnt1, s_conflict_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign dsp_out   = dsp_sub   ? dsp_in1 - dsp_in2     : dsp_in1 + dsp_in2;
    assign s_dsp_out = s_dsp_sub ? s_dsp_in1 - s_dsp_in2 : s_dsp_in1 + s_dsp_in2;

    dsp_addsub_arbiter #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_sub(req_sub), .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .dsp_in1(dsp_in1), .dsp_in2(dsp_in2), .dsp_sub(dsp_sub), .dsp_out(dsp_out),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
    );

    dsp_addsub_arbiter #(.WIDTH(WIDTH), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_sub(req_sub), .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data0(s_rsp_data0), .rsp_data1(s_rsp_data1),
        .dsp_in1(s_dsp_in1), .dsp_in2(s_dsp_in2), .dsp_sub(s_dsp_sub), .dsp_out(s_dsp_out),
        .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1), .conflict_cnt(s_conflict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; req_sub = 2'b00; rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        repeat (2) tick();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data0", rsp_data0, 32'h0);
        chk("reset_grant_cnt0", 32'(grant_cnt0), 32'h0);
        chk("reset_conflict", 32'(conflict_cnt), 32'h0);
        chk("reset_dsp_in1", dsp_in1, 32'h0);
        chk("reset_dsp_sub", 32'(dsp_sub), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single add on port 0
        req_valid = 2'b01; req_a0 = 32'h5; req_b0 = 32'h3; req_sub = 2'b00;
        #1;
        chk("add_req_ready", 32'(req_ready), 32'h1);
        chk("add_dsp_in1", dsp_in1, 32'h5);
        tick();
        req_valid = 2'b00;
        #1;
        chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("add_rsp_data0", rsp_data0, 32'h8);
        chk("add_dsp_sub_held", 32'(dsp_sub), 32'h0);
        chk("add_dsp_in2_held", dsp_in2, 32'h3);
        chk("add_grant_cnt0", 32'(grant_cnt0), 32'h1);
        rsp_ready = 2'b01;
        tick();
        chk("add_drained", 32'(rsp_valid), 32'h0);

        // Subtract wrap on port 1
        req_valid = 2'b10; req_a1 = 32'h1; req_b1 = 32'h2; req_sub = 2'b10; rsp_ready = 2'b00;
        #1;
        chk("sub_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        #1;
        chk("sub_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("sub_rsp_data1", rsp_data1, 32'hFFFF_FFFF);
        chk("sub_dsp_sub_held", 32'(dsp_sub), 32'h1);
        rsp_ready = 2'b11;
        tick();

        // Contention: port 1 won last, so port 0 goes first
        req_valid = 2'b11; req_a0 = 32'd10; req_b0 = 32'd1; req_a1 = 32'd20; req_b1 = 32'd3;
        req_sub = 2'b10; rsp_ready = 2'b11;
        #1;
        chk("cont_grant0", 32'(req_ready), 32'h1);
        tick();
        chk("cont_grant1", 32'(req_ready), 32'h2);
        tick();
        chk("cont_grant2", 32'(req_ready), 32'h1);
        tick();
        chk("cont_grant3", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        #1;
        chk("cont_conflict", 32'(conflict_cnt), 32'd4);
        chk("cont_grant_cnt0", 32'(grant_cnt0), 32'd3);
        chk("cont_grant_cnt1", 32'(grant_cnt1), 32'd3);
        chk("cont_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("cont_rsp_data1", rsp_data1, 32'd17);
        chk("cont_rsp_data0", rsp_data0, 32'd11);
        tick();

        // Backpressure on port 0
        rsp_ready = 2'b00; req_valid = 2'b01; req_a0 = 32'd100; req_b0 = 32'd1; req_sub = 2'b00;
        tick();
        req_a0 = 32'd200; req_b0 = 32'd50; req_sub = 2'b01;
        #1;
        chk("bp_blocked", 32'(req_ready), 32'h0);
        chk("bp_data", rsp_data0, 32'd101);
        tick();
        chk("bp_data_held", rsp_data0, 32'd101);
        chk("bp_valid_held", 32'(rsp_valid), 32'h1);
        chk("bp_dsp_hold", dsp_in1, 32'd100);
        rsp_ready = 2'b01;
        #1;
        chk("bp_grant_on_drain", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("bp_valid_stays", 32'(rsp_valid), 32'h1);
        chk("bp_new_data", rsp_data0, 32'd150);
        chk("bp_grant_cnt0", 32'(grant_cnt0), 32'd5);
        tick();
        chk("bp_drained", 32'(rsp_valid), 32'h0);

        // Async reset mid-operation; port 0 won last, yet reset re-prefers port 0
        req_valid = 2'b01; req_a0 = 32'd7; req_b0 = 32'd7; req_sub = 2'b00; rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("arst_rsp_data0", rsp_data0, 32'h0);
        chk("arst_grant_cnt0", 32'(grant_cnt0), 32'h0);
        chk("arst_conflict", 32'(conflict_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("arst_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;

        // Saturation: 20 grants to port 0 from a clean reset
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        rsp_ready = 2'b01; req_valid = 2'b01; req_sub = 2'b00;
        repeat (20) tick();
        req_valid = 2'b00;
        #1;
        chk("sat_cnt4", 32'(s_grant_cnt0), 32'd15);
        chk("sat_cnt16", 32'(grant_cnt0), 32'd20);
        chk("sat_cnt4_port1", 32'(s_grant_cnt1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
